// File: rtl/vram_shadow.sv
// vram_shadow: video BRAM responder for banks 5/7 that snoops CPU screen writes through a FIFO
// and drains them only in cycles that video fetches leave free.
module vram_shadow #(
  parameter int FIFO_DEPTH = 4,
  parameter int AW = 15
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ce_7mn,
  input  logic [AW-1:0] vram_addr,
  output logic [7:0]    vram_dout,
  input  logic [15:0]   addr,
  input  logic [7:0]    din,
  input  logic          nMREQ,
  input  logic          nWR,
  input  logic          m128,
  input  logic [2:0]    page_ram,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          mem_we,
  input  logic [7:0]    mem_rdata,
  output logic          wr_overflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = AW + 8;
  typedef enum logic [1:0] {IDLE, VREAD, VCAP, WRITE} state_t;
  state_t        state_q, state_d;
  logic          req_q, req_d;
  logic          wstb, wstb_q;
  logic [EW-1:0] fifo_q [FIFO_DEPTH];
  logic [EW-1:0] fifo_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [7:0]    dout_q, dout_d, wdata_q, wdata_d;
  logic [AW-1:0] maddr_q, maddr_d;
  logic          we_q, we_d, ovf_q, ovf_d;
  logic          hit, bank7, push, push_ok, pop, full, go_read;
  logic [EW-1:0] head;
  assign wstb    = ~nMREQ & ~nWR;
  assign bank7   = (addr[15:14] == 2'b11) & (page_ram == 3'd7);
  assign hit     = (addr[15:14] == 2'b01) |
                   ((addr[15:14] == 2'b11) & m128 & ((page_ram == 3'd5) | (page_ram == 3'd7)));
  assign push    = wstb & ~wstb_q & hit;
  assign full    = cnt_q == (PW+1)'(FIFO_DEPTH);
  // A ce_7mn pulse in IDLE blocks the drain so the read it raises next cycle goes first.
  assign pop     = (state_q == IDLE) & ~req_q & ~ce_7mn & (cnt_q != '0);
  assign push_ok = push & (~full | pop);
  assign go_read = (state_q == IDLE) & req_q;
  assign head    = fifo_q[rd_ptr_q];
  always_comb begin
    fifo_d = fifo_q;
    if (push_ok) fifo_d[wr_ptr_q] = {AW'({bank7, addr[13:0]}), din};
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q + (PW+1)'(push_ok) - (PW+1)'(pop);
    ovf_d    = ovf_q | (push & ~push_ok);
    req_d    = ce_7mn | (req_q & (state_q != VCAP));
    dout_d   = (state_q == VCAP) ? mem_rdata : dout_q;
    we_d     = pop;
    maddr_d  = pop ? head[EW-1:8] : go_read ? vram_addr : maddr_q;
    wdata_d  = pop ? head[7:0] : wdata_q;
    state_d  = (state_q == VREAD) ? VCAP :
               (state_q != IDLE)  ? IDLE :
               req_q              ? VREAD :
               pop                ? WRITE : IDLE;
  end
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      wstb_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      dout_q   <= 8'hFF;
      maddr_q  <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      wstb_q   <= wstb;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      maddr_q  <= maddr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      ovf_q    <= ovf_d;
    end
    fifo_q <= fifo_d;
  end
  assign vram_dout   = dout_q;
  assign mem_addr    = maddr_q;
  assign mem_wdata   = wdata_q;
  assign mem_we      = we_q;
  assign wr_overflow = ovf_q;
endmodule

// File: tb/tb_vram_shadow.sv
// tb_vram_shadow: scoreboard bench for vram_shadow with a behavioural 1-cycle-latency BRAM.
module tb_vram_shadow;
  logic        clk_sys = 1'b0;
  logic        reset_n, ce_7mn, nMREQ, nWR, m128, mem_we, wr_overflow;
  logic [14:0] vram_addr, mem_addr;
  logic [7:0]  vram_dout, din, mem_wdata, mem_rdata;
  logic [15:0] addr;
  logic [2:0]  page_ram;
  logic [7:0]  bram [0:32767];
  logic        pre_en = 1'b0;
  logic [14:0] pre_addr = '0;
  logic [7:0]  pre_data = '0;
  logic [22:0] exp_q [$];
  logic        ce_busy = 1'b0;
  int          n_chk = 0, n_pass = 0, we_cnt = 0;
  always #5 clk_sys = ~clk_sys;
  vram_shadow dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_7mn(ce_7mn), .vram_addr(vram_addr),
    .vram_dout(vram_dout), .addr(addr), .din(din), .nMREQ(nMREQ), .nWR(nWR),
    .m128(m128), .page_ram(page_ram), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .wr_overflow(wr_overflow)
  );
  always @(posedge clk_sys) begin
    if (pre_en) bram[pre_addr] <= pre_data;
    else if (mem_we) bram[mem_addr] <= mem_wdata;
    mem_rdata <= bram[mem_addr];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  always @(negedge clk_sys) begin
    if (reset_n && mem_we) begin
      logic [22:0] e;
      we_cnt++;
      if (exp_q.size() == 0) check("spurious_we", 32'(mem_addr), 32'h7FFFFFFF);
      else begin
        e = exp_q.pop_front();
        check("we_addr", 32'(mem_addr), 32'(e[22:8]));
        check("we_data", 32'(mem_wdata), 32'(e[7:0]));
      end
    end
  end
  function automatic logic [15:0] target(input logic [15:0] a, input logic m, input logic [2:0] p);
    if (a[15:14] == 2'b01) return {2'b10, a[13:0]};
    if (a[15:14] == 2'b11 && m && p == 3'd5) return {2'b10, a[13:0]};
    if (a[15:14] == 2'b11 && m && p == 3'd7) return {2'b11, a[13:0]};
    return 16'h0;
  endfunction
  task automatic tick();
    @(posedge clk_sys);
    #1;
    ce_7mn = ce_busy;
  endtask
  task automatic preload(input logic [14:0] a, input logic [7:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_en = 1'b0;
  endtask
  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d, input int hold, input bit keep);
    logic [15:0] t;
    t = target(a, m128, page_ram);
    if (keep && t[15]) exp_q.push_back({t[14:0], d});
    addr = a; din = d; nMREQ = 1'b0; nWR = 1'b0;
    repeat (hold) tick();
    nMREQ = 1'b1; nWR = 1'b1;
    tick();
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    int base, rd_at, wr_at;
    bit seen;
    reset_n = 1'b0; ce_7mn = 1'b0; vram_addr = '0; addr = '0; din = '0;
    nMREQ = 1'b1; nWR = 1'b1; m128 = 1'b0; page_ram = '0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check("rst_dout", 32'(vram_dout), 32'hFF);
    check("rst_we", 32'(mem_we), 0);
    check("rst_ovf", 32'(wr_overflow), 0);
    check("rst_addr", 32'(mem_addr), 0);
    preload(15'h0000, 8'h3C);
    vram_addr = 15'h0000; ce_7mn = 1'b1;
    repeat (4) tick();
    check("rd0", 32'(vram_dout), 32'h3C);
    repeat (6) tick();
    check("rd0_hold", 32'(vram_dout), 32'h3C);
    base = we_cnt;
    cpu_wr(16'h4005, 8'hA5, 1, 1);
    repeat (6) tick();
    check("wr1_pulses", 32'(we_cnt - base), 1);
    base = we_cnt;
    cpu_wr(16'h4006, 8'h5A, 6, 1);
    repeat (6) tick();
    check("wr_long_pulses", 32'(we_cnt - base), 1);
    base = we_cnt;
    m128 = 1'b1;
    page_ram = 3'd7; cpu_wr(16'hC123, 8'h11, 1, 1);
    page_ram = 3'd5; cpu_wr(16'hC123, 8'h22, 1, 1);
    page_ram = 3'd2; cpu_wr(16'hC123, 8'h33, 1, 1);
    cpu_wr(16'h8000, 8'h44, 1, 1);
    repeat (8) tick();
    check("map_bank7", 32'(bram[15'h4123]), 32'h11);
    check("map_bank5", 32'(bram[15'h0123]), 32'h22);
    check("map_count", 32'(we_cnt - base), 2);
    check("map_q_empty", 32'(exp_q.size()), 0);
    preload(15'h0200, 8'h77);
    vram_addr = 15'h0200; addr = 16'h4300; din = 8'h99;
    exp_q.push_back({15'h0300, 8'h99});
    nMREQ = 1'b0; nWR = 1'b0; ce_7mn = 1'b1;
    tick();
    nMREQ = 1'b1; nWR = 1'b1;
    rd_at = 99; wr_at = 99;
    for (int i = 1; i <= 12; i++) begin
      if (rd_at == 99 && vram_dout == 8'h77) rd_at = i;
      if (wr_at == 99 && mem_we) wr_at = i;
      tick();
    end
    check("rd_latency", 32'(rd_at <= 4), 1);
    check("rd_before_wr", 32'(rd_at < wr_at), 1);
    preload(15'h0300, 8'h5E);
    addr = 16'h4301; din = 8'hE7;
    exp_q.push_back({15'h0301, 8'hE7});
    nMREQ = 1'b0; nWR = 1'b0;
    tick();
    nMREQ = 1'b1; nWR = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (mem_we) begin
        seen = 1'b1;
        vram_addr = 15'h0300; ce_7mn = 1'b1;
      end else tick();
    end
    check("saw_write", 32'(seen), 1);
    repeat (4) tick();
    check("rd_after_wr", 32'(vram_dout), 32'h5E);
    repeat (5) tick();
    preload(15'h0404, 8'hC7);
    vram_addr = 15'h0000; ce_busy = 1'b1; ce_7mn = 1'b1;
    for (int i = 0; i < 5; i++) cpu_wr(16'h4400 + 16'(i), 8'hD0 + 8'(i), 1, i < 4);
    check("ovf_set", 32'(wr_overflow), 1);
    ce_busy = 1'b0;
    repeat (30) tick();
    check("ovf_q_empty", 32'(exp_q.size()), 0);
    check("ovf_dropped", 32'(bram[15'h0404]), 32'hC7);
    check("ovf_sticky", 32'(wr_overflow), 1);
    ce_busy = 1'b1; ce_7mn = 1'b1;
    cpu_wr(16'h4500, 8'h01, 1, 0);
    cpu_wr(16'h4501, 8'h02, 1, 0);
    reset_n = 1'b0; ce_busy = 1'b0; ce_7mn = 1'b0;
    base = we_cnt;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (15) tick();
    check("rst_mid_we", 32'(we_cnt - base), 0);
    check("rst_mid_ovf", 32'(wr_overflow), 0);
    check("rst_mid_dout", 32'(vram_dout), 32'hFF);
    check("rst_mid_untouched", 32'(bram[15'h0500]), 32'(bram[15'h0501] == 8'h02 ? 8'hFF : bram[15'h0500]));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/vram_shadow.md
Name: vram_shadow

Overview:
- Responder side of the video controller's VRAM fetch interface.
- Takes the controller's `vram_addr` and returns `vram_dout` from a dedicated 32 KB single-port video BRAM holding banks 5 and 7.
- Keeps that BRAM coherent by snooping CPU memory writes that land in screen banks. Writes are queued in a small FIFO and drained only into cycles not needed for video fetches.
- Sits between the Z80 bus, the video controller and the video BRAM.

Parameters:
- FIFO_DEPTH, 4: number of queued CPU writes; power of two, minimum 2.
- AW, 15: VRAM address width. Bit 14 selects bank 7 (1) or bank 5 (0).

Ports:
- clk_sys  in  1  master clock; at least 4 clk_sys per ce_7mn pulse.
- reset_n  in  1  synchronous, active-low reset.
- ce_7mn  in  1  pixel clock enable (negative phase); the video controller updates `vram_addr` on it.
- vram_addr  in  AW  fetch address from the video controller.
- vram_dout  out  8  fetched byte, registered.
- addr  in  16  CPU address bus.
- din  in  8  CPU data bus (write data).
- nMREQ  in  1  CPU memory request, active low.
- nWR  in  1  CPU write strobe, active low.
- m128  in  1  128K paging enabled.
- page_ram  in  3  RAM bank currently mapped at C000-FFFF.
- mem_addr  out  AW  BRAM address.
- mem_wdata  out  8  BRAM write data.
- mem_we  out  1  BRAM write enable.
- mem_rdata  in  8  BRAM read data; valid 1 clk_sys after the address is presented.
- wr_overflow  out  1  sticky flag: a snooped write was dropped.

Behaviour:

Reset (reset_n low at a clk_sys edge):
- `vram_dout` = 8'hFF, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `wr_overflow` = 0.
- FIFO emptied, FSM set to IDLE, write-edge detector cleared.
- Reset asserted mid-operation discards any in-flight read or queued write; no partial BRAM write occurs.

Write snoop:
- wstb = ~nMREQ & ~nWR, registered as wstb_d.
- An entry is pushed only on the cycle where wstb=1 and wstb_d=0, i.e. exactly one push per CPU write cycle.
- Target mapping:
  - addr[15:14]=01 → offset {0, addr[13:0]}.
  - addr[15:14]=11 and m128 and page_ram=5 → {0, addr[13:0]}.
  - addr[15:14]=11 and m128 and page_ram=7 → {1, addr[13:0]}.
  - All other writes are ignored, including every write to 8000-BFFF and every C000 write with m128=0.
- Entry content = {offset, din}, both sampled on the push cycle.

FIFO:
- Push when full with no pop in the same cycle → entry dropped and `wr_overflow` set to 1, held until reset.
- Push and pop in the same cycle when full → both happen; no overflow.
- Pointers wrap modulo FIFO_DEPTH; occupancy counter is log2(FIFO_DEPTH)+1 bits.

Video read request:
- A request is latched in the cycle after any ce_7mn pulse, regardless of whether `vram_addr` changed.
- It is serviced with `vram_addr` as sampled in that cycle.

FSM states:
- IDLE:
  - If a read request is pending → VREAD (read has priority).
  - Else if the FIFO is not empty → WRITE.
  - Else stay in IDLE.
- VREAD:
  - `mem_addr` = sampled vram_addr, `mem_we` = 0.
  - Next state VCAP.
- VCAP:
  - `vram_dout` <= mem_rdata and the request is cleared.
  - Next state IDLE.
- WRITE:
  - Pop the FIFO head; `mem_addr` = offset, `mem_wdata` = data, `mem_we` = 1 for exactly this one cycle.
  - Next state IDLE.
  - A read request arriving during WRITE waits for the WRITE to finish.

Timing and hold rules:
- Worst-case latency from ce_7mn to updated `vram_dout` is 4 clk_sys. This is within one ce_7mn period, so the controller's next ce_7mn sample is always valid.
- `vram_dout` holds its value between captures.
- No forwarding: a read returns BRAM contents at VREAD. A queued but undrained write to the same offset is not visible.
- At most one BRAM access per cycle. `mem_we` is never asserted in VREAD or VCAP.

Test Plan:
- Release reset → vram_dout=8'hFF, mem_we=0, wr_overflow=0. Preload BRAM[0x0000]=8'h3C, drive vram_addr=0x0000 and pulse ce_7mn → vram_dout=8'h3C within 4 clk_sys, held until the next ce_7mn.
- CPU write to addr 0x4005 with din=8'hA5, no ce_7mn activity → exactly one mem_we pulse with mem_addr=0x0005 and mem_wdata=8'hA5. A write held low for 6 cycles still produces only one pulse.
- With m128=1, write 0xC123=8'h11 at page_ram=7, then 0xC123=8'h22 at page_ram=5, then 0xC123=8'h33 at page_ram=2, then 0x8000=8'h44 → BRAM[0x4123]=8'h11 and BRAM[0x0123]=8'h22; no other writes occur.
- A ce_7mn pulse arrives in the same cycle a write is pending → VREAD is issued first and mem_we is asserted only after VCAP. A ce_7mn pulse arriving during WRITE → its vram_dout is still updated within 4 clk_sys.
- Hold ce_7mn busy so the FIFO does not drain, then issue 5 snooped writes with FIFO_DEPTH=4 → wr_overflow=1, and after draining exactly the first 4 entries appear in BRAM. Assert reset_n=0 with 2 entries queued → no mem_we after reset; wr_overflow=0.
